// File: rtl/serial_pkg.sv
// Shared types for the serial transmit path: the parity-mode selector and the framing FSM state.
package serial_pkg;

  typedef enum logic [1:0] {
    NONE,
    ODD,
    EVEN
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/serial_tx_fifo_if.sv
// Write-side bus of the serial transmitter: data/strobe in, FIFO status out.
interface serial_tx_fifo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 txe;
  logic                 full;
  logic                 overflow;

  modport master (output data, txe, input full, overflow);
  modport slave  (input data, txe, output full, overflow);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rdata always shows the head entry.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + (AW+1)'(1);
      if (do_rd) rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/serial_tx_fifo.sv
// FIFO-buffered asynchronous serial transmitter: start bit, LSB-first data, optional parity, stop bits.
module serial_tx_fifo
  import serial_pkg::*;
#(
  parameter int unsigned DIVISOR    = 434,
  parameter int unsigned DATA_BITS  = 8,
  parameter parity_e     PARITY     = NONE,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_tx_fifo_if.slave       bus,
  output logic                  tx,
  output logic                  busy
);
  localparam int unsigned CNT_W = $clog2(DIVISOR);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIVISOR - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 stop_q, stop_d;
  logic                 tx_q, tx_d;
  logic                 rst_q;
  logic                 overflow_q;
  logic                 pop;
  logic                 bit_end;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (bus.txe),
    .wdata (bus.data),
    .rd    (pop && rst_q),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.full     = fifo_full;
  assign bus.overflow = overflow_q;
  assign tx           = tx_q;
  assign busy         = (state_q != S_IDLE) || !fifo_empty;

  // The write side sees raw rst_n so a write on the first edge after release
  // lands in the FIFO; the framer waits one extra edge via rst_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 1'b0;
    else        rst_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       overflow_q <= 1'b0;
    else if (bus.txe && fifo_full)    overflow_q <= 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    bit_end = (cnt_q == CNT_MAX);

    if (state_q != S_IDLE) cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = fifo_rdata;
          par_d   = (PARITY == EVEN) ? ^fifo_rdata : ~^fifo_rdata;
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_d    = sh_q[0];
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            if (PARITY == NONE) begin
              tx_d    = 1'b1;
              stop_d  = 1'b0;
              state_d = S_STOP;
            end else begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end
          end else begin
            tx_d  = sh_q[1];
            sh_d  = sh_q >> 1;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            if (!fifo_empty) begin
              pop     = 1'b1;
              sh_d    = fifo_rdata;
              par_d   = (PARITY == EVEN) ? ^fifo_rdata : ~^fifo_rdata;
              tx_d    = 1'b0;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else if (!rst_q) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Drives six differently configured transmitters from one write stream and compares every cycle
// against a frame-level model (queue of words -> list of line bits, each held DIVISOR clocks).
module tb_serial_tx_fifo;
  import serial_pkg::*;

  localparam int NDUT = 6;
  localparam int unsigned DIV [NDUT] = '{4, 4, 4, 4, 8, 3};
  localparam int unsigned DB  [NDUT] = '{8, 8, 8, 8, 8, 7};
  localparam parity_e     PAR [NDUT] = '{NONE, EVEN, ODD, NONE, NONE, ODD};
  localparam int unsigned SB  [NDUT] = '{1, 1, 1, 2, 1, 2};
  localparam int unsigned DEP [NDUT] = '{16, 16, 16, 16, 4, 2};

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic txe_r  = 1'b0;
  logic [8:0] data_r = '0;
  logic [NDUT-1:0] tx_v, busy_v, full_v, ovf_v;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    serial_tx_fifo_if #(.DATA_BITS(DB[g])) bus ();
    logic tx_w;
    logic busy_w;
    assign bus.data  = data_r[DB[g]-1:0];
    assign bus.txe   = txe_r;
    assign tx_v[g]   = tx_w;
    assign busy_v[g] = busy_w;
    assign full_v[g] = bus.full;
    assign ovf_v[g]  = bus.overflow;

    serial_tx_fifo #(
      .DIVISOR    (DIV[g]),
      .DATA_BITS  (DB[g]),
      .PARITY     (PAR[g]),
      .STOP_BITS  (SB[g]),
      .FIFO_DEPTH (DEP[g])
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .tx    (tx_w),
      .busy  (busy_w)
    );
  end

  // Reference model state
  logic [8:0]  fmem [NDUT][16];
  int          fhead [NDUT];
  int          fcnt  [NDUT];
  int          fpos  [NDUT];
  int          flen  [NDUT];
  logic [15:0] fbits [NDUT];
  logic        exp_tx [NDUT];
  logic        exp_busy [NDUT];
  logic        exp_full [NDUT];
  logic        exp_ovf [NDUT];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NDUT; i++) begin
      fhead[i] = 0; fcnt[i] = 0; fpos[i] = 0; flen[i] = 0; fbits[i] = '0;
      exp_tx[i] = 1'b1; exp_busy[i] = 1'b0; exp_full[i] = 1'b0; exp_ovf[i] = 1'b0;
    end
  endfunction

  function automatic void model_step(int i, logic we, logic [8:0] d);
    logic       full_before;
    logic       popped;
    logic       par;
    logic [8:0] w;
    logic [8:0] mask;
    int         b;
    int         div;
    div = int'(DIV[i]);
    mask = 9'((1 << DB[i]) - 1);
    full_before = (fcnt[i] == int'(DEP[i]));
    popped = 1'b0;
    if (fpos[i] >= flen[i] * div && fcnt[i] > 0) begin
      w = fmem[i][fhead[i]];
      fhead[i] = (fhead[i] + 1) % int'(DEP[i]);
      fcnt[i]--;
      fbits[i] = '0;
      fbits[i][0] = 1'b0;
      b = 1;
      for (int k = 0; k < int'(DB[i]); k++) begin
        fbits[i][b] = w[k];
        b++;
      end
      if (PAR[i] != NONE) begin
        par = ^w;
        if (PAR[i] == ODD) par = ~par;
        fbits[i][b] = par;
        b++;
      end
      for (int k = 0; k < int'(SB[i]); k++) begin
        fbits[i][b] = 1'b1;
        b++;
      end
      flen[i] = b;
      fpos[i] = 0;
    end
    if (fpos[i] < flen[i] * div) begin
      exp_tx[i] = fbits[i][fpos[i] / div];
      fpos[i]++;
      popped = 1'b1;
    end else begin
      exp_tx[i] = 1'b1;
    end
    if (we) begin
      if (full_before) exp_ovf[i] = 1'b1;
      else begin
        fmem[i][(fhead[i] + fcnt[i]) % int'(DEP[i])] = d & mask;
        fcnt[i]++;
      end
    end
    exp_busy[i] = popped || (fcnt[i] > 0);
    exp_full[i] = (fcnt[i] == int'(DEP[i]));
  endfunction

  task automatic check_all();
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("tx[%0d]", i),   32'(tx_v[i]),   32'(exp_tx[i]));
      check($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(exp_busy[i]));
      check($sformatf("full[%0d]", i), 32'(full_v[i]), 32'(exp_full[i]));
      check($sformatf("ovf[%0d]", i),  32'(ovf_v[i]),  32'(exp_ovf[i]));
    end
  endtask

  task automatic tick(input logic we, input logic [8:0] d);
    txe_r  = we;
    data_r = d;
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int i = 0; i < NDUT; i++) model_step(i, we, d);
    #1;
    txe_r = 1'b0;
    check_all();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (busy_v != '0 && n < budget) begin
      tick(1'b0, '0);
      n++;
    end
    check("drain", 32'(busy_v), 32'(0));
    repeat (3) tick(1'b0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) tick(1'b0, '0);
    rst_n = 1'b1;
    repeat (2) tick(1'b0, '0);

    // Single word: 8N1, even/odd parity, two stop bits, 7-bit odd variants
    tick(1'b1, 9'h059);
    drain(300);

    // Back-to-back frames
    tick(1'b1, 9'h000);
    tick(1'b1, 9'h0FF);
    drain(400);

    // Burst of six: overflows the shallow FIFOs
    for (int k = 0; k < 6; k++) tick(1'b1, 9'($urandom));
    drain(1500);

    tick(1'b1, 9'h041);
    drain(300);

    // Random traffic, sparse then dense
    for (int n = 0; n < 1500; n++) tick(($urandom_range(0, 31) == 0), 9'($urandom));
    for (int n = 0; n < 200; n++)  tick(($urandom_range(0, 3) == 0), 9'($urandom));
    drain(4000);

    // Reset in the middle of data bit 3 of the first frame, two words still queued
    tick(1'b1, 9'h0A5);
    tick(1'b1, 9'h03C);
    tick(1'b1, 9'h0C3);
    repeat (16) tick(1'b0, '0);
    rst_n = 1'b0;
    #1;
    check("rst_tx",   32'(tx_v),   32'({NDUT{1'b1}}));
    check("rst_busy", 32'(busy_v), 32'(0));
    check("rst_full", 32'(full_v), 32'(0));
    check("rst_ovf",  32'(ovf_v),  32'(0));
    model_reset();
    repeat (3) tick(1'b0, '0);
    rst_n = 1'b1;
    repeat (30) tick(1'b0, '0);

    // Write in the very first cycle after release
    rst_n = 1'b0;
    repeat (2) tick(1'b0, '0);
    rst_n = 1'b1;
    tick(1'b1, 9'h133);
    drain(300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_tx_fifo.md
SERIAL_TX_FIFO -- requirements
Module: serial_tx_fifo

Interface
REQ-001 Parameter DIVISOR, default 434: clocks per bit period; legal range 2..2^20.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default NONE: frame parity mode; values NONE, ODD, EVEN.
REQ-004 Parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 16: transmit FIFO entries; power of two, minimum 2.
REQ-006 clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 data  input  DATA_BITS  word to transmit; sampled when txe=1.
REQ-009 txe  input  1  write strobe; one word accepted per cycle while high and not full.
REQ-010 tx  output  1  serial line; idle high.
REQ-011 full  output  1  FIFO holds FIFO_DEPTH words.
REQ-012 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-013 overflow  output  1  sticky; set when txe=1 while full=1.

Function
REQ-014 Frame, in order: 1 start bit (0), DATA_BITS data bits LSB first, parity bit if PARITY!=NONE, STOP_BITS stop bits (1).
REQ-015 Parity: EVEN makes the total count of ones over data+parity even; ODD makes it odd.
REQ-016 Every bit, including each stop bit, drives tx for exactly DIVISOR clocks; the baud counter counts 0..DIVISOR-1 and wraps.
REQ-017 FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START when FIFO non-empty; START->DATA after one bit; DATA->PARITY (or STOP when PARITY=NONE) after DATA_BITS bits; PARITY->STOP after one bit; STOP->START if FIFO non-empty else IDLE after STOP_BITS bits.
REQ-018 FIFO pop and shift-register load occur on the IDLE->START and STOP->START edges; tx is registered and goes low on that same edge.
REQ-019 Latency: a word written on edge N into an empty FIFO while IDLE drives tx low after edge N+1.
REQ-020 Back-to-back frames: no idle cycles between the last stop bit and the next start bit when the FIFO is non-empty.
REQ-021 txe while full: word dropped, FIFO unchanged, overflow set; drop applies even if a pop occurs on the same edge (full is evaluated before the edge).
REQ-022 txe on the pop edge with FIFO not full: both occur; word count unchanged net.
REQ-023 data and txe are not required to be held; data is captured into the FIFO on the write edge.
REQ-024 overflow clears only on reset.
REQ-025 busy deasserts on the edge the FSM enters IDLE with the FIFO empty.

Reset
REQ-026 rst_n low asynchronously forces: state IDLE, baud counter 0, FIFO empty, tx=1, full=0, busy=0, overflow=0.
REQ-027 Reset mid-frame aborts the frame; tx returns high immediately; queued words are discarded.
REQ-028 Release of rst_n is synchronised internally so the first active edge is clean; txe in the first cycle after release is accepted.

Structure
REQ-029 Shared package serial_pkg holds the parity-mode enumeration (NONE, ODD, EVEN) and the FSM state typedef.
REQ-030 The FIFO is a sub-module sync_fifo (parametrised width/depth, write, read, full, empty); framing FSM, baud counter and shift register live in serial_tx_fifo.

Verification
REQ-031 DIVISOR=4, 8N1, write 0x59 once -> tx low after edge N+1, then bits 1,0,0,1,1,0,1,0 then stop 1, each 4 clocks; frame 40 clocks; busy falls at frame end.
REQ-032 DIVISOR=4, PARITY=EVEN then ODD, write 0x59 -> parity bit 0 (EVEN) and 1 (ODD) after bit 7; frame 44 clocks.
REQ-033 DIVISOR=4, STOP_BITS=2, write 0x00 and 0xFF back-to-back -> second start bit immediately follows 8 stop clocks; no extra idle cycles; 88 clocks total.
REQ-034 FIFO_DEPTH=4, DIVISOR=8, write 6 words in consecutive cycles -> first pops into the shifter, 4 stored, full asserted, 6th dropped, overflow=1; exactly 5 frames transmitted.
REQ-035 DATA_BITS=7, PARITY=ODD, write 7'h41 -> frame 0,1,0,0,0,0,0,1,1(parity),1; 10 bits.
REQ-036 Assert rst_n low in the middle of bit 3 of a frame with 2 words queued -> tx=1 immediately, busy=0, full=0; after release no frame starts without a new write.
